// File: rtl/spi_flash_reader_if.sv
// Command / read-data handshake between a user controller (master) and
// spi_flash_reader (slave).
interface spi_flash_reader_if;
  logic        cmd_strobe;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_abort;
  logic [7:0]  rd_data;
  logic        rd_strobe;
  logic        rd_ready;
  logic        busy;
  logic        done;

  modport master (
    output cmd_strobe, cmd_addr, cmd_len, cmd_abort, rd_ready,
    input  rd_data, rd_strobe, busy, done
  );

  modport slave (
    input  cmd_strobe, cmd_addr, cmd_len, cmd_abort, rd_ready,
    output rd_data, rd_strobe, busy, done
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 initiator issuing READ (0x03) to a NOR flash and streaming the
// returned bytes out over a strobed, backpressured byte interface.
module spi_flash_reader #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic              clk,
  input  logic              reset,
  spi_flash_reader_if.slave bus,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DESEL = 3'd6
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(DIVISOR - 1);
  localparam logic [7:0] CMD_READ   = 8'h03;

  state_t      state_r;
  logic [7:0]  phase_r;
  logic [4:0]  bit_r;
  logic [31:0] shift_r;
  logic [7:0]  rx_r;
  logic [15:0] remain_r;
  logic        cs_r;
  logic        sck_r;
  logic        mosi_r;
  logic        busy_r;
  logic        done_r;
  logic        strobe_r;
  logic [7:0]  rd_data_r;

  logic        phase_end_s;
  logic        abortable_s;
  logic        abort_s;
  logic        start_s;
  logic [7:0]  rx_next_s;

  // Decode end-of-phase, abort eligibility and start request.
  always_comb begin
    phase_end_s = (phase_r == 8'd0);
    rx_next_s   = {rx_r[6:0], spi_miso};
    start_s     = bus.cmd_strobe && (bus.cmd_len != 16'd0);
    case (state_r)
      ST_SETUP, ST_CMD, ST_DATA, ST_WAIT: abortable_s = 1'b1;
      default:                            abortable_s = 1'b0;
    endcase
    abort_s = abortable_s && bus.cmd_abort;
  end

  // Transaction sequencer; every pin and handshake output is a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      phase_r   <= 8'd0;
      bit_r     <= 5'd0;
      shift_r   <= 32'd0;
      rx_r      <= 8'd0;
      remain_r  <= 16'd0;
      cs_r      <= 1'b1;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      strobe_r  <= 1'b0;
      rd_data_r <= 8'd0;
    end else begin
      done_r   <= 1'b0;
      strobe_r <= 1'b0;
      if (abort_s) begin
        // A partially shifted byte is simply dropped here.
        state_r <= ST_HOLD;
        phase_r <= PHASE_LAST;
        bit_r   <= 5'd0;
        sck_r   <= 1'b0;
        mosi_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_s) begin
              state_r  <= ST_SETUP;
              phase_r  <= PHASE_LAST;
              bit_r    <= 5'd0;
              shift_r  <= {CMD_READ, bus.cmd_addr};
              remain_r <= bus.cmd_len;
              cs_r     <= 1'b0;
              busy_r   <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (phase_end_s) begin
              state_r <= ST_CMD;
              phase_r <= PHASE_LAST;
              mosi_r  <= shift_r[31];
            end else begin
              phase_r <= phase_r - 8'd1;
            end
          end
          ST_CMD: begin
            if (!phase_end_s) begin
              phase_r <= phase_r - 8'd1;
            end else if (!sck_r) begin
              phase_r <= PHASE_LAST;
              sck_r   <= 1'b1;
            end else if (bit_r == 5'd31) begin
              phase_r <= PHASE_LAST;
              sck_r   <= 1'b0;
              bit_r   <= 5'd0;
              mosi_r  <= 1'b0;
              rx_r    <= 8'd0;
              state_r <= bus.rd_ready ? ST_DATA : ST_WAIT;
            end else begin
              phase_r <= PHASE_LAST;
              sck_r   <= 1'b0;
              bit_r   <= bit_r + 5'd1;
              shift_r <= {shift_r[30:0], 1'b0};
              mosi_r  <= shift_r[30];
            end
          end
          ST_DATA: begin
            if (!phase_end_s) begin
              phase_r <= phase_r - 8'd1;
            end else if (!sck_r) begin
              phase_r <= PHASE_LAST;
              sck_r   <= 1'b1;
            end else begin
              // Last cycle of the high phase: sample MISO as SCK falls.
              phase_r <= PHASE_LAST;
              sck_r   <= 1'b0;
              rx_r    <= rx_next_s;
              if (bit_r == 5'd7) begin
                bit_r     <= 5'd0;
                strobe_r  <= 1'b1;
                rd_data_r <= rx_next_s;
                if (remain_r != 16'd0) begin
                  remain_r <= remain_r - 16'd1;
                end
                if (remain_r <= 16'd1) begin
                  state_r <= ST_HOLD;
                end else begin
                  state_r <= bus.rd_ready ? ST_DATA : ST_WAIT;
                end
              end else begin
                bit_r <= bit_r + 5'd1;
              end
            end
          end
          ST_WAIT: begin
            if (bus.rd_ready) begin
              state_r <= ST_DATA;
              phase_r <= PHASE_LAST;
            end
          end
          ST_HOLD: begin
            if (phase_end_s) begin
              state_r <= ST_DESEL;
              phase_r <= PHASE_LAST;
              bit_r   <= 5'd0;
              cs_r    <= 1'b1;
            end else begin
              phase_r <= phase_r - 8'd1;
            end
          end
          ST_DESEL: begin
            // Deselect spans two phase periods; bit_r[0] marks the second.
            if (!phase_end_s) begin
              phase_r <= phase_r - 8'd1;
            end else if (bit_r[0]) begin
              state_r <= ST_IDLE;
              bit_r   <= 5'd0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              phase_r <= PHASE_LAST;
              bit_r   <= 5'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cs_r    <= 1'b1;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_cs        = cs_r;
  assign spi_clk       = sck_r;
  assign spi_mosi      = mosi_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.rd_strobe = strobe_r;
  assign bus.rd_data   = rd_data_r;

endmodule
